half_adder_checker: RTL

Sequential response checker that sits on the output side of a half adder under test. It receives sampled `{a, b, sum, carry}` tuples under a valid strobe and compares each against the expected `sum = a ^ b`, `carry = a & b`. It counts checks and mismatches, captures the first failing tuple, and tracks coverage of the four input combinations. It reports done/pass once every combination has been seen, or on an optional watchdog timeout.

---
 rtl/half_adder_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/half_adder_checker.sv
// Response checker for a half adder: counts checks/mismatches, records first failure, tracks {a,b} coverage.
// Optional watchdog compiled in with HA_CHK_TIMEOUT_EN (cycle budget TIMEOUT).
module half_adder_checker #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic [3:0]       first_fail,
    output logic             fail_seen,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic       mismatch;
    logic       accept;
    logic [3:0] cov_upd;
    logic       cov_done;
    logic       wd_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign mismatch = (sum != (a ^ b)) || (carry != (a & b));
    // start outranks a simultaneous tuple, so the tuple is dropped on a restart edge
    assign accept   = (state == RUN) && in_valid && !start;
    assign cov_upd  = coverage | (4'b0001 << {a, b});
    assign cov_done = accept && (cov_upd == 4'b1111);

`ifdef HA_CHK_TIMEOUT_EN
    logic [15:0] wd;

    assign wd_hit = (state == RUN) && !start && ((wd + 16'd1) == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (start) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (state == RUN) begin
            wd <= wd + 16'd1;
            // coverage completing on the budget edge counts as a normal finish
            if (wd_hit && !cov_done)
                timeout <= 1'b1;
        end
    end
`else
    // a zero budget is outside the legal range, so this never fires
    assign wd_hit  = (TMO == 16'd0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (start)         state_next = RUN;
                else if (cov_done) state_next = DONE;
                else if (wd_hit)   state_next = DONE;
            end
            DONE: if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
            coverage   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (start) begin
                pass       <= 1'b0;
                chk_count  <= '0;
                err_count  <= '0;
                coverage   <= '0;
                first_fail <= '0;
                fail_seen  <= 1'b0;
            end else if (accept) begin
                chk_count <= sat_inc(chk_count);
                coverage  <= cov_upd;
                if (mismatch) begin
                    err_count <= sat_inc(err_count);
                    if (!fail_seen) begin
                        first_fail <= {a, b, sum, carry};
                        fail_seen  <= 1'b1;
                    end
                end
                if (cov_done)
                    pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule
